position_writeback_controller: RTL

//  Write side of the double-buffered particle position memory. Accepts updated positions from the

---
 rtl/position_writeback_if.sv | 23 ++
 rtl/position_writeback_controller.sv | 98 +++++++++
 2 files changed

// File: rtl/position_writeback_if.sv
// Stream-in / memory-write bundle for the position write-back controller.
// The controller takes the slave side; the upstream pipeline and memory model take the master side.
interface position_writeback_if #(
    parameter int DWIDTH = 96
);
    logic              in_valid;
    logic [DWIDTH-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic [31:0]       waddr;
    logic [DWIDTH-1:0] wdata;
    logic              we;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, waddr, wdata, we
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, waddr, wdata, we
    );
endinterface

// File: rtl/position_writeback_controller.sv
// Writes one pass of updated positions into the inactive bank, then flips the bank select.
// Optional POSWB_ZERO_FILL_EN: an early in_last zero-fills the rest of the bank before the swap.
module position_writeback_controller #(
    parameter int DBSIZE = 256,
    parameter int DWIDTH = 96
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    position_writeback_if.slave  bus,
    output logic                 double_buffer,
    output logic                 busy,
    output logic                 done
);
    localparam int CW = $clog2(DBSIZE) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DBSIZE - 1);

`ifdef POSWB_ZERO_FILL_EN
    typedef enum logic [1:0] {IDLE, WRITE, FILL, SWAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, WRITE, SWAP} state_t;
`endif

    state_t          state;
    logic [CW-1:0]   count;
    logic [31:0]     base;
    logic [31:0]     addr;
    logic            accept;

    // Writes always target the bank the readers are not using.
    assign base     = double_buffer ? 32'd0 : DBSIZE[31:0];
    assign addr     = base + 32'(count);
    assign bus.in_ready = (state == WRITE);
    assign accept   = bus.in_valid & bus.in_ready;
    assign busy     = (state != IDLE);

`ifndef POSWB_ZERO_FILL_EN
    logic in_last_unused;
    assign in_last_unused = bus.in_last;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            double_buffer <= 1'b0;
            bus.we        <= 1'b0;
            bus.waddr     <= '0;
            bus.wdata     <= '0;
            done          <= 1'b0;
        end else begin
            bus.we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= WRITE;
                        count <= '0;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        bus.we    <= 1'b1;
                        bus.waddr <= addr;
                        bus.wdata <= bus.in_data;
                        count     <= count + 1'b1;
                        if (count == LAST_CNT) begin
                            state <= SWAP;
                        end
`ifdef POSWB_ZERO_FILL_EN
                        else if (bus.in_last) begin
                            state <= FILL;
                        end
`endif
                    end
                end
`ifdef POSWB_ZERO_FILL_EN
                FILL: begin
                    bus.we    <= 1'b1;
                    bus.waddr <= addr;
                    bus.wdata <= '0;
                    count     <= count + 1'b1;
                    if (count == LAST_CNT) begin
                        state <= SWAP;
                    end
                end
`endif
                SWAP: begin
                    // Final write is on the bus this cycle; readers see the flip only afterwards.
                    double_buffer <= ~double_buffer;
                    done          <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
